mb8_arbiter: RTL
================

Name: mb8_arbiter

Overview:
- Shares the single 8-bit memory port (spram8_128k on mb8_io) between two requesters.
- Port 0 is the Forth core (fetch and data access); port 1 is the loader/DMA that fills the dictionary image and TIB.
- Provides per-port accept/read-valid handshakes, burst locking for streaming loads, and a starvation guard.
- Sits between the requesters and the memory slave; all memory traffic passes through it.

Parameters:
- DSZ, 8, data width in bits.
- ASZ, 17, address width (128K bytes).
- MAXWAIT, 16, cycles a pending requester may be blocked by a lock before the lock is broken; range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- m0_req  in  1  port 0 requests one byte access this cycle.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_lock  in  1  port 0 asks to keep ownership after this beat.
- m0_ai  in  ASZ  port 0 address.
- m0_vi  in  DSZ  port 0 write data.
- m0_ack  out  1  port 0 beat accepted this cycle.
- m0_rv  out  1  port 0 read data valid.
- m0_vo  out  DSZ  port 0 read data.
- m1_req, m1_we, m1_lock, m1_ai, m1_vi, m1_ack, m1_rv, m1_vo: same meaning for port 1.
- mem_we  out  1  memory write enable.
- mem_ai  out  ASZ  memory address.
- mem_vi  out  DSZ  memory write data.
- mem_vo  in  DSZ  memory read data, valid 1 cycle after the read address.
- owner  out  2  debug: 0 = IDLE, 1 = OWN0, 2 = OWN1.

Behaviour:
- Reset (rst = 0 at a clk edge): state IDLE; ack, rv, mem_we = 0; mem_ai = 0; mem_vi = 0; m*_vo = 0; wait counter = 0; rr pointer = 0. Any in-flight read is dropped, and no rv is issued for it.
- Memory outputs are a combinational mux of the granted port's request. With no grant: mem_we = 0, mem_ai = 0, mem_vi = 0.
- One beat per cycle. A port's ack is high in the same cycle as its req when granted; the port holds req and its fields until acked.
- Read latency is 1. An acked read at cycle N gives rv = 1 and vo = mem_vo at cycle N+1, routed to the issuing port only. Writes produce no rv. Back-to-back reads give rv on consecutive cycles.
- State IDLE:
  - Grant by the priority rule (below) among requesting ports.
  - If the granted beat has lock = 1, go to OWN0 or OWN1 for that port; otherwise stay IDLE.
- State OWNx:
  - Port x is granted whenever it requests; the other port is blocked.
  - An acked beat with lock = 0 returns to IDLE.
  - If port x drops req while owning, ownership is held for 1 idle cycle, then returns to IDLE.
- Starvation guard:
  - The wait counter increments each cycle the non-owner requests while in OWNx.
  - On reaching MAXWAIT, the current owner's next acked beat is treated as lock = 0. The blocked port then wins the next arbitration regardless of priority.
  - The counter clears on leaving OWNx.
- Simultaneous requests in IDLE (default): port 0 wins.
- Address and data pass through unchanged, with no width conversion.

Optional Feature:
- Macro MB8_ARB_RR_EN.
- Defined: round-robin priority in IDLE. The rr pointer flips to the other port after each grant to a port; ties go to the port the pointer names.
- Undefined: fixed priority, port 0 always wins ties, and the rr pointer is absent.

Decomposition:
- Package mb8_arb_pkg:
  - typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_st_t;
  - localparams for port ids.
  - A struct {we, ai, vi} for the muxed request.
- One sub-module, mb8_rd_track: a 1-deep register of {valid, port id} that routes mem_vo to m0_vo or m1_vo and generates rv.

Test Plan:
- Reset: hold rst = 0 for 2 cycles while both ports request. Required: all ack, rv, mem_we = 0; owner = IDLE.
- Lone read: m1 reads x0005 (memory holds x31). Required: m1_ack at N; m1_rv = 1 and m1_vo = x31 at N+1; m0_rv stays 0.
- Tie: both ports write in IDLE (m0 x10 to x0100, m1 x20 to x0200). Required: m0 acked first, m1 acked the next cycle; readback gives x10, x20. With MB8_ARB_RR_EN, repeat the tie: m1 wins the second round.
- Locked burst: m1 streams 8 writes with lock = 1 while m0 requests continuously, MAXWAIT = 4. Required: the lock breaks after 4 blocked cycles; m0 acked on the cycle after m1's 5th ack; m1 resumes afterwards.
- Reset mid-read: assert rst in the cycle after m0's read ack. Required: no m0_rv; state IDLE on the next cycle.

Source files
------------

// File: rtl/mb8_arb_pkg.sv
// Shared types for the two-port mb8 memory arbiter.
// Port ids, owner states and the muxed memory request bundle.
package mb8_arb_pkg;

    localparam int MB8_DSZ = 8;
    localparam int MB8_ASZ = 17;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_st_t;

    typedef struct packed {
        logic               we;
        logic [MB8_ASZ-1:0] ai;
        logic [MB8_DSZ-1:0] vi;
    } mem_req_t;

    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/mb8_rd_track.sv
// One-deep read tracker: remembers which port issued the last read
// and steers the memory read data back to it one cycle later.
module mb8_rd_track
    import mb8_arb_pkg::*;
#(
    parameter int DSZ = MB8_DSZ
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           issue,
    input  logic           issue_port,
    input  logic [DSZ-1:0] mem_vo,
    output logic           rv0,
    output logic           rv1,
    output logic [DSZ-1:0] vo0,
    output logic [DSZ-1:0] vo1
);

    logic valid;
    logic port;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            port  <= PORT0;
        end else begin
            valid <= issue;
            port  <= issue_port;
        end
    end

    // A read in flight when reset arrives never reports valid
    assign rv0 = rst && valid && (port == PORT0);
    assign rv1 = rst && valid && (port == PORT1);
    assign vo0 = rv0 ? mem_vo : '0;
    assign vo1 = rv1 ? mem_vo : '0;

endmodule

// File: rtl/mb8_arbiter.sv
// Two-port arbiter for the shared 8-bit spram port, with burst lock
// and starvation guard; define MB8_ARB_RR_EN for round-robin ties.
module mb8_arbiter
    import mb8_arb_pkg::*;
#(
    parameter int DSZ     = MB8_DSZ,
    parameter int ASZ     = MB8_ASZ,
    parameter int MAXWAIT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           m0_req,
    input  logic           m0_we,
    input  logic           m0_lock,
    input  logic [ASZ-1:0] m0_ai,
    input  logic [DSZ-1:0] m0_vi,
    output logic           m0_ack,
    output logic           m0_rv,
    output logic [DSZ-1:0] m0_vo,
    input  logic           m1_req,
    input  logic           m1_we,
    input  logic           m1_lock,
    input  logic [ASZ-1:0] m1_ai,
    input  logic [DSZ-1:0] m1_vi,
    output logic           m1_ack,
    output logic           m1_rv,
    output logic [DSZ-1:0] m1_vo,
    output logic           mem_we,
    output logic [ASZ-1:0] mem_ai,
    output logic [DSZ-1:0] mem_vi,
    input  logic [DSZ-1:0] mem_vo,
    output logic [1:0]     owner
);

    localparam logic [7:0] MW = 8'(MAXWAIT);

    arb_st_t    st;
    arb_st_t    st_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       fav_v;
    logic       fav_v_nxt;
    logic       fav_p;
    logic       fav_p_nxt;
    logic       gnt0;
    logic       gnt1;
    logic       own;
    logic       own_req;
    logic       own_lock;
    logic       blocked;
    logic       brk;
    mem_req_t   req_mux;
`ifdef MB8_ARB_RR_EN
    logic       rr;
    logic       rr_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            st    <= IDLE;
            cnt   <= '0;
            fav_v <= 1'b0;
            fav_p <= PORT0;
`ifdef MB8_ARB_RR_EN
            rr    <= PORT0;
`endif
        end else begin
            st    <= st_nxt;
            cnt   <= cnt_nxt;
            fav_v <= fav_v_nxt;
            fav_p <= fav_p_nxt;
`ifdef MB8_ARB_RR_EN
            rr    <= rr_nxt;
`endif
        end
    end

    always_comb begin
        st_nxt    = st;
        cnt_nxt   = cnt;
        fav_v_nxt = fav_v;
        fav_p_nxt = fav_p;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        own       = PORT0;
        own_req   = 1'b0;
        own_lock  = 1'b0;
        blocked   = 1'b0;
        brk       = 1'b0;

        unique case (st)
            IDLE: begin
                // A port starved out of a lock jumps the queue once
                if (fav_v && (fav_p ? m1_req : m0_req)) begin
                    gnt0 = (fav_p == PORT0);
                    gnt1 = (fav_p == PORT1);
                end else if (m0_req && m1_req) begin
`ifdef MB8_ARB_RR_EN
                    gnt0 = (rr == PORT0);
                    gnt1 = (rr == PORT1);
`else
                    gnt0 = 1'b1;
`endif
                end else begin
                    gnt0 = m0_req;
                    gnt1 = m1_req;
                end
                if (gnt0 || gnt1)
                    fav_v_nxt = 1'b0;
                if (gnt0 && m0_lock)
                    st_nxt = OWN0;
                else if (gnt1 && m1_lock)
                    st_nxt = OWN1;
            end
            OWN0, OWN1: begin
                own      = (st == OWN1) ? PORT1 : PORT0;
                own_req  = own ? m1_req : m0_req;
                own_lock = own ? m1_lock : m0_lock;
                blocked  = own ? m0_req : m1_req;
                gnt0     = (own == PORT0) && m0_req;
                gnt1     = (own == PORT1) && m1_req;
                if (blocked && (cnt != 8'hff))
                    cnt_nxt = cnt + 8'd1;
                brk = (cnt_nxt >= MW);
                // Owner going quiet costs exactly this one held cycle
                if (!own_req || !own_lock || brk) begin
                    st_nxt  = IDLE;
                    cnt_nxt = '0;
                    if (brk) begin
                        fav_v_nxt = 1'b1;
                        fav_p_nxt = other_port(own);
                    end
                end
            end
            default: begin
                st_nxt  = IDLE;
                cnt_nxt = '0;
            end
        endcase

        if (!rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

`ifdef MB8_ARB_RR_EN
    always_comb begin
        rr_nxt = rr;
        if (gnt0)
            rr_nxt = PORT1;
        else if (gnt1)
            rr_nxt = PORT0;
    end
`endif

    always_comb begin
        req_mux = '0;
        if (gnt0)
            req_mux = '{we: m0_we, ai: m0_ai, vi: m0_vi};
        else if (gnt1)
            req_mux = '{we: m1_we, ai: m1_ai, vi: m1_vi};
    end

    assign mem_we = req_mux.we;
    assign mem_ai = req_mux.ai;
    assign mem_vi = req_mux.vi;
    assign m0_ack = gnt0;
    assign m1_ack = gnt1;
    assign owner  = st;

    mb8_rd_track #(
        .DSZ(DSZ)
    ) u_rd_track (
        .clk       (clk),
        .rst       (rst),
        .issue     ((gnt0 && !m0_we) || (gnt1 && !m1_we)),
        .issue_port(gnt1 ? PORT1 : PORT0),
        .mem_vo    (mem_vo),
        .rv0       (m0_rv),
        .rv1       (m1_rv),
        .vo0       (m0_vo),
        .vo1       (m1_vo)
    );

endmodule
